// File: rtl/div16s_8s_seq.sv
// div16s_8s_seq: sequential signed divider, 16-bit dividend by 8-bit divisor.
// A restoring shift-subtract core works on operand magnitudes and produces one
// quotient bit per cycle. A final FIX cycle applies signs, saturation and the
// divide-by-zero result. The latency is constant for every operand pair.
// DROP_LSB zeroes low dividend bits so truncated multiplier products divide
// on the same terms as exact ones.
module div16s_8s_seq #(
  parameter int DROP_LSB = 0
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  quotient,
  output logic [7:0]  remainder,
  output logic        ovf,
  output logic        dz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [15:0] DVD_MASK = ~((16'd1 << DROP_LSB) - 16'd1);

  state_t      state_r;
  state_t      next_state_s;

  logic [15:0] dvd_mag_r;       // dividend magnitude, consumed MSB first
  logic [15:0] quo_mag_r;       // quotient magnitude, filled LSB side
  logic [7:0]  prem_r;          // partial remainder (always below divisor magnitude)
  logic [7:0]  dsr_mag_r;
  logic        dvd_neg_r;
  logic        dsr_neg_r;
  logic        dz_cap_r;
  logic [3:0]  count_r;
  logic [7:0]  quotient_r;
  logic [7:0]  remainder_r;
  logic        ovf_r;
  logic        dz_r;
  logic        out_valid_r;

  logic        accept_s;
  logic [15:0] dvd_masked_s;
  logic [15:0] dvd_abs_s;
  logic [7:0]  dsr_abs_s;
  logic [8:0]  prem_shift_s;
  logic        ge_s;
  logic [7:0]  prem_next_s;
  logic        qneg_s;
  logic        over_s;
  logic [7:0]  fix_quotient_s;
  logic [7:0]  fix_remainder_s;
  logic        fix_ovf_s;

  assign accept_s     = in_valid & (state_r == IDLE);
  assign dvd_masked_s = dividend & DVD_MASK;
  assign dvd_abs_s    = dvd_masked_s[15] ? (~dvd_masked_s + 16'd1) : dvd_masked_s;
  assign dsr_abs_s    = divisor[7] ? (~divisor + 8'd1) : divisor;

  // The 9-bit shifted remainder is compared in full. When it is at least the
  // divisor, the true difference is below the divisor (<= 128), so an 8-bit
  // difference is exact.
  assign prem_shift_s = {prem_r, dvd_mag_r[15]};
  assign ge_s         = prem_shift_s >= {1'b0, dsr_mag_r};
  assign prem_next_s  = ge_s ? (prem_shift_s[7:0] - dsr_mag_r) : prem_shift_s[7:0];

  assign qneg_s = dvd_neg_r ^ dsr_neg_r;
  assign over_s = qneg_s ? (quo_mag_r > 16'd128) : (quo_mag_r > 16'd127);

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: accept, 16 iterations, one fix-up cycle, hold until consumed.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) next_state_s = CALC;
        else          next_state_s = IDLE;
      end
      CALC: begin
        if (count_r == 4'd15) next_state_s = FIX;
        else                  next_state_s = CALC;
      end
      FIX:  next_state_s = DONE;
      DONE: begin
        if (out_ready) next_state_s = IDLE;
        else           next_state_s = DONE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Handshake output decoded from the state register only.
  always_comb begin
    in_ready = 1'b0;
    if (state_r == IDLE) in_ready = 1'b1;
    else                 in_ready = 1'b0;
  end

  // Sign, saturation and divide-by-zero fix-up of the magnitude result.
  always_comb begin
    fix_quotient_s  = 8'h00;
    fix_remainder_s = 8'h00;
    fix_ovf_s       = 1'b0;
    if (dz_cap_r) begin
      fix_quotient_s  = dvd_neg_r ? 8'h80 : 8'h7F;
      fix_remainder_s = 8'h00;
      fix_ovf_s       = 1'b0;
    end else begin
      if (over_s) begin
        fix_ovf_s      = 1'b1;
        fix_quotient_s = qneg_s ? 8'h80 : 8'h7F;
      end else begin
        fix_ovf_s      = 1'b0;
        fix_quotient_s = qneg_s ? (8'd0 - quo_mag_r[7:0]) : quo_mag_r[7:0];
      end
      fix_remainder_s = dvd_neg_r ? (8'd0 - prem_r) : prem_r;
    end
  end

  // Datapath: operand capture, shift-subtract iterations and result registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      dvd_mag_r   <= 16'd0;
      quo_mag_r   <= 16'd0;
      prem_r      <= 8'd0;
      dsr_mag_r   <= 8'd0;
      dvd_neg_r   <= 1'b0;
      dsr_neg_r   <= 1'b0;
      dz_cap_r    <= 1'b0;
      count_r     <= 4'd0;
      quotient_r  <= 8'd0;
      remainder_r <= 8'd0;
      ovf_r       <= 1'b0;
      dz_r        <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            dvd_mag_r <= dvd_abs_s;
            dsr_mag_r <= dsr_abs_s;
            dvd_neg_r <= dvd_masked_s[15];
            dsr_neg_r <= divisor[7];
            dz_cap_r  <= (divisor == 8'd0);
            prem_r    <= 8'd0;
            quo_mag_r <= 16'd0;
            count_r   <= 4'd0;
          end
        end
        CALC: begin
          prem_r    <= prem_next_s;
          quo_mag_r <= {quo_mag_r[14:0], ge_s};
          dvd_mag_r <= {dvd_mag_r[14:0], 1'b0};
          count_r   <= count_r + 4'd1;
        end
        FIX: begin
          quotient_r  <= fix_quotient_s;
          remainder_r <= fix_remainder_s;
          ovf_r       <= fix_ovf_s;
          dz_r        <= dz_cap_r;
          out_valid_r <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid_r <= 1'b0;
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign quotient  = quotient_r;
  assign remainder = remainder_r;
  assign ovf       = ovf_r;
  assign dz        = dz_r;

endmodule
